// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, overflow codes and divider FSM states.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    localparam logic [1:0] OVF_NONE = 2'b00;
    localparam logic [1:0] OVF_HI   = 2'b01;
    localparam logic [1:0] OVF_LO   = 2'b10;

    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [MAN_W-1:0] MAN_ZERO = '0;
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_div_iter.sv
// Combinational restoring-division step chain: ITERS_PER_CYC trial subtractions per call.
module fp_div_iter #(
    parameter int unsigned ITERS_PER_CYC = 1
) (
    input  logic [24:0]              rem,
    input  logic [23:0]              mb,
    output logic [24:0]              rem_next,
    output logic [ITERS_PER_CYC-1:0] qbits
);

    logic [24:0] r;
    logic [25:0] diff;

    // Remainder stays below mb (< 2^24) after each step, so the shift never loses a set bit.
    always_comb begin
        r     = rem;
        diff  = '0;
        qbits = '0;
        for (int unsigned i = 0; i < ITERS_PER_CYC; i++) begin
            diff = {1'b0, r} - {2'b00, mb};
            qbits[ITERS_PER_CYC-1-i] = ~diff[25];
            if (!diff[25])
                r = diff[24:0];
            r = {r[23:0], 1'b0};
        end
        rem_next = r;
    end

endmodule

// File: rtl/fp_div.sv
// Iterative IEEE-754 single divider with valid/ready handshakes.
// Optional IEEE Inf/NaN decoding is enabled by defining FP_DIV_SPECIALS_EN.
module fp_div
    import fp_pkg::*;
#(
    parameter int unsigned ITERS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] flout_a,
    input  logic [31:0] flout_b,
    input  logic        round_cfg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] flout_c,
    output logic [1:0]  overflow
);

    if (ITERS_PER_CYC != 1 && ITERS_PER_CYC != 2) begin : g_bad_iters
        $error("fp_div: ITERS_PER_CYC must be 1 or 2");
    end

    localparam logic [4:0] CNT_LAST = 5'(26 / ITERS_PER_CYC - 1);

    state_t             state;
    logic               sign;
    logic               rnd;
    logic signed [9:0]  ed;
    logic [MAN_W:0]     mb;
    logic [24:0]        rem;
    logic [25:0]        q;
    logic [4:0]         cnt;

    logic [24:0]              rem_next;
    logic [ITERS_PER_CYC-1:0] qbits;

    logic [7:0]  ea, eb;
    logic        s_in, a_zero, b_zero;
    logic        special;
    logic [31:0] spec_c;
    logic [1:0]  spec_ovf;

    assign in_ready = (state == IDLE) & rst;

    assign ea     = flout_a[30:23];
    assign eb     = flout_b[30:23];
    assign s_in   = flout_a[31] ^ flout_b[31];
    assign a_zero = (ea == EXP_ZERO);
    assign b_zero = (eb == EXP_ZERO);

`ifdef FP_DIV_SPECIALS_EN
    logic a_inf, b_inf, a_nan, b_nan;
    assign a_inf = (ea == EXP_MAX) && (flout_a[22:0] == MAN_ZERO);
    assign b_inf = (eb == EXP_MAX) && (flout_b[22:0] == MAN_ZERO);
    assign a_nan = (ea == EXP_MAX) && (flout_a[22:0] != MAN_ZERO);
    assign b_nan = (eb == EXP_MAX) && (flout_b[22:0] != MAN_ZERO);
`endif

    always_comb begin
        special  = 1'b0;
        spec_c   = '0;
        spec_ovf = OVF_NONE;
`ifdef FP_DIV_SPECIALS_EN
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            special  = 1'b1;
            spec_c   = QNAN;
            spec_ovf = OVF_HI;
        end else if (a_inf || b_zero) begin
            special  = 1'b1;
            spec_c   = {s_in, EXP_MAX, MAN_ZERO};
            spec_ovf = OVF_HI;
        end else if (b_inf || a_zero) begin
            special  = 1'b1;
        end
`else
        if (b_zero) begin
            special  = 1'b1;
            spec_c   = {s_in, EXP_MAX, MAN_ZERO};
            spec_ovf = OVF_HI;
        end else if (a_zero) begin
            special  = 1'b1;
        end
`endif
    end

    fp_div_iter #(.ITERS_PER_CYC(ITERS_PER_CYC)) u_iter (
        .rem      (rem),
        .mb       (mb),
        .rem_next (rem_next),
        .qbits    (qbits)
    );

    logic [22:0]       frac_t, frac_r;
    logic              rbit;
    logic signed [9:0] e_t, e_r;
    logic [23:0]       frac_inc;

    always_comb begin
        if (q[25]) begin
            frac_t = q[24:2];
            rbit   = q[1];
            e_t    = ed;
        end else begin
            frac_t = q[23:1];
            rbit   = q[0];
            e_t    = ed - 10'sd1;
        end
        frac_inc = {1'b0, frac_t} + 24'd1;
        frac_r   = frac_t;
        e_r      = e_t;
        if (rnd && rbit) begin
            frac_r = frac_inc[22:0];
            if (frac_inc[23])
                e_r = e_t + 10'sd1;
        end
    end

    // Special results are written on the accepting edge; out_valid follows one edge later in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            flout_c   <= '0;
            overflow  <= OVF_NONE;
            sign      <= 1'b0;
            rnd       <= 1'b0;
            ed        <= '0;
            mb        <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= s_in;
                        rnd  <= round_cfg;
                        ed   <= {2'b00, ea} - {2'b00, eb} + 10'(BIAS);
                        mb   <= {1'b1, flout_b[22:0]};
                        rem  <= {2'b01, flout_a[22:0]};
                        q    <= '0;
                        cnt  <= '0;
                        if (special) begin
                            flout_c  <= spec_c;
                            overflow <= spec_ovf;
                            state    <= DONE;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= rem_next;
                    q   <= {q[25-ITERS_PER_CYC:0], qbits};
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST)
                        state <= NORM;
                end
                NORM: begin
                    if (e_r >= 10'sd255) begin
                        flout_c  <= {sign, EXP_MAX, MAN_ZERO};
                        overflow <= OVF_HI;
                    end else if (e_r <= 10'sd0) begin
                        flout_c  <= '0;
                        overflow <= OVF_LO;
                    end else begin
                        flout_c  <= {sign, e_r[7:0], frac_r};
                        overflow <= OVF_NONE;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
